led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 106 ++++++++++
 tb/tb_led_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: button-controlled 8-LED pattern sequencer (COUNT/SHIFT/BOUNCE/BLINK)
// Ports:
//   clk       in   design clock
//   resetn    in   asynchronous active-low reset
//   btn_mode  in   raw async button, advances mode on each press
//   btn_pause in   raw async button, toggles pause on each press
//   leds      out  [7:0] registered LED drive (inverted when LED_ACTIVE_LOW)
//   mode      out  [1:0] current mode
//   step_tick out  one-cycle pulse on each pattern step
//   paused    out  pause state
module led_sequencer #(
    parameter int unsigned PRESCALE       = 1000000,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_mode,
    input  logic       btn_pause,
    output logic [7:0] leds,
    output logic [1:0] mode,
    output logic       step_tick,
    output logic       paused
);
    typedef enum logic [1:0] {COUNT, SHIFT, BOUNCE, BLINK} mode_e;

    localparam logic [23:0] LAST = 24'(PRESCALE - 1);

    // bit 0 = mode button, bit 1 = pause button
    logic [1:0] s1_q, s2_q, s3_q, arm_q, evt_q, evt_d, vld_q;

    mode_e       mode_q, mode_nx;
    logic [7:0]  pat_q, pat_init, pat_step, bnc;
    logic        dir_q, dir_step, onehot, tick;
    logic        paused_q;
    logic [23:0] cnt_q;

    // vld_q marks when s2_q reflects the real pin rather than reset zeros;
    // a button is only armed after it has been seen low, so a button held
    // across reset release produces no event until released and pressed again.
    assign evt_d = s2_q & ~s3_q & arm_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            arm_q <= '0;
            evt_q <= '0;
        end else begin
            vld_q <= {vld_q[0], 1'b1};
            s1_q  <= {btn_pause, btn_mode};
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            arm_q <= arm_q | ({2{vld_q[1]}} & ~s2_q);
            evt_q <= evt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !paused_q;

    always_comb begin
        mode_nx  = mode_e'(mode_q + 2'd1);
        pat_init = mode_nx == COUNT ? 8'h00 : mode_nx == BLINK ? 8'hFF : 8'h01;
        onehot   = $onehot(pat_q);
        bnc      = dir_q ? {1'b0, pat_q[7:1]} : {pat_q[6:0], 1'b0};
        pat_step = mode_q == COUNT  ? pat_q + 8'd1 :
                   mode_q == SHIFT  ? (onehot ? {pat_q[6:0], pat_q[7]} : 8'h01) :
                   mode_q == BOUNCE ? (onehot ? bnc : 8'h01) : ~pat_q;
        // dir flips on reaching an end so each end appears once per sweep
        dir_step = mode_q != BOUNCE ? dir_q :
                   !onehot          ? 1'b0 :
                   bnc == 8'h80     ? 1'b1 :
                   bnc == 8'h01     ? 1'b0 : dir_q;
    end

    // mode event wins over a coincident step; pause toggles independently
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q   <= COUNT;
            pat_q    <= 8'h00;
            dir_q    <= 1'b0;
            paused_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            paused_q <= paused_q ^ evt_q[1];
            if (evt_q[0]) begin
                mode_q <= mode_nx;
                pat_q  <= pat_init;
                dir_q  <= 1'b0;
                cnt_q  <= '0;
            end else if (tick) begin
                pat_q <= pat_step;
                dir_q <= dir_step;
                cnt_q <= '0;
            end else if (!paused_q) begin
                cnt_q <= cnt_q + 24'd1;
            end
        end
    end

    assign leds      = LED_ACTIVE_LOW ? ~pat_q : pat_q;
    assign mode      = mode_q;
    assign step_tick = tick;
    assign paused    = paused_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed self-checking bench for led_sequencer at PRESCALE=4
// Ports: none (drives clk/resetn/buttons, checks leds/mode/step_tick/paused)
module tb_led_sequencer;
    logic       clk = 1'b0, resetn = 1'b0, btn_mode = 1'b0, btn_pause = 1'b0;
    logic [7:0] leds, leds_l;
    logic [1:0] mode, mode_l;
    logic       step_tick, tick_l, paused, paused_l;
    int         tests = 0, fails = 0, nt = 0;
    logic [7:0] bexp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    always #5 clk = ~clk;

    led_sequencer #(.PRESCALE(4), .LED_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .resetn(resetn), .btn_mode(btn_mode), .btn_pause(btn_pause),
        .leds(leds), .mode(mode), .step_tick(step_tick), .paused(paused)
    );

    led_sequencer #(.PRESCALE(4), .LED_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .resetn(resetn), .btn_mode(btn_mode), .btn_pause(btn_pause),
        .leds(leds_l), .mode(mode_l), .step_tick(tick_l), .paused(paused_l)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press_mode(input logic [1:0] m, input logic [7:0] l);
        btn_mode = 1'b1;
        step(4);
        btn_mode = 1'b0;
        check("mode", 32'(mode), 32'(m));
        check("mode_leds", 32'(leds), 32'(l));
    endtask

    initial begin
        step(3);
        check("rst_leds", 32'(leds), 32'h00);
        check("rst_leds_l", 32'(leds_l), 32'hFF);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_tick", 32'(step_tick), 32'd0);
        resetn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(2);
            check("cnt_notick", 32'(step_tick), 32'd0);
            step(1);
            check("cnt_tick", 32'(step_tick), 32'd1);
            check("cnt_hold", 32'(leds), 32'(i - 1));
            step(1);
            check("cnt_leds", 32'(leds), 32'(i));
            check("cnt_tick_lo", 32'(step_tick), 32'd0);
        end
        check("cnt_leds_l", 32'(leds_l), 32'hFC);
        press_mode(2'd1, 8'h01);
        step(6);
        press_mode(2'd2, 8'h01);
        step(6);
        press_mode(2'd3, 8'hFF);
        step(6);
        press_mode(2'd0, 8'h00);
        step(6);
        press_mode(2'd1, 8'h01);
        step(6);
        press_mode(2'd2, 8'h01);
        for (int k = 0; k < 16; k++) begin
            step(4);
            check("bounce", 32'(leds), 32'(bexp[k]));
        end
        step(6);
        press_mode(2'd3, 8'hFF);
        step(6);
        press_mode(2'd0, 8'h00);
        step(16);
        check("pre_pause", 32'(leds), 32'h04);
        step(2);
        btn_pause = 1'b1;
        step(4);
        btn_pause = 1'b0;
        check("pause_on", 32'(paused), 32'd1);
        check("pause_leds", 32'(leds), 32'h05);
        repeat (50) begin
            step(1);
            if (step_tick) nt++;
        end
        check("pause_ticks", 32'(nt), 32'd0);
        check("pause_hold", 32'(leds), 32'h05);
        btn_pause = 1'b1;
        step(4);
        btn_pause = 1'b0;
        check("pause_off", 32'(paused), 32'd0);
        check("resume_leds", 32'(leds), 32'h05);
        check("resume_notick", 32'(step_tick), 32'd0);
        step(1);
        check("resume_tick", 32'(step_tick), 32'd1);
        step(1);
        check("resume_step", 32'(leds), 32'h06);
        btn_mode = 1'b1;
        step(3);
        check("coll_tick", 32'(step_tick), 32'd1);
        check("coll_pre", 32'(leds), 32'h06);
        step(1);
        btn_mode = 1'b0;
        check("coll_mode", 32'(mode), 32'd1);
        check("coll_leds", 32'(leds), 32'h01);
        check("coll_tick_lo", 32'(step_tick), 32'd0);
        step(2);
        check("coll_gap", 32'(step_tick), 32'd0);
        step(1);
        check("coll_next_tick", 32'(step_tick), 32'd1);
        step(1);
        check("coll_next_leds", 32'(leds), 32'h02);
        step(6);
        press_mode(2'd2, 8'h01);
        step(6);
        press_mode(2'd3, 8'hFF);
        btn_pause = 1'b1;
        step(4);
        btn_pause = 1'b0;
        check("blink_paused", 32'(paused), 32'd1);
        check("blink_mode", 32'(mode), 32'd3);
        btn_mode = 1'b1;
        step(2);
        resetn = 1'b0;
        #1;
        check("arst_leds", 32'(leds), 32'h00);
        check("arst_leds_l", 32'(leds_l), 32'hFF);
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_paused", 32'(paused), 32'd0);
        check("arst_tick", 32'(step_tick), 32'd0);
        step(2);
        resetn = 1'b1;
        step(3);
        check("rel_tick", 32'(step_tick), 32'd1);
        check("rel_leds", 32'(leds), 32'h00);
        step(7);
        check("held_mode", 32'(mode), 32'd0);
        check("held_leds", 32'(leds), 32'h02);
        btn_mode = 1'b0;
        step(5);
        press_mode(2'd1, 8'h01);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
